vrf_multibank: RTL
==================

VRF_MULTIBANK -- requirements
Module: vrf_multibank

Interface
REQ-001 SHALL have parameter LANES, default 8, number of vector lanes (power of two, 2..16).
REQ-002 SHALL have parameter NREGS, default 32, number of architectural vector registers (power of two, 8..32).
REQ-003 SHALL have parameter ELEN, default 32, element width per lane in bits (8, 16, 32 or 64).
REQ-004 SHALL have parameter MASK_REG, default 0, register index used as mask source.
REQ-005 SHALL have parameter BYPASS, default 1, 1 = same-cycle write-to-read forwarding enabled.
REQ-006 SHALL have port clk  input  1  the single clock; all state updates on its rising edge.
REQ-007 SHALL have port rst  input  1  reset, synchronous and active-high.
REQ-008 SHALL have port ready  output  1  high when register clear is complete and the file accepts traffic.
REQ-009 SHALL have ports rs1_addr, rs2_addr  input  log2(NREGS)  read port addresses.
REQ-010 SHALL have ports rs1_data, rs2_data, mask_data  output  LANES*ELEN  read data, lane 0 in the LSBs.
REQ-011 SHALL have ports rs1_busy, rs2_busy  output  1  scoreboard busy bit of the addressed register.
REQ-012 SHALL have ports wr_addr  input  log2(NREGS); wr_en  input  LANES; wr_data  input  LANES*ELEN; wr_masked  input  1; wr_last  input  1.
REQ-013 SHALL have ports rsv_valid  input  1; rsv_addr  input  log2(NREGS): scoreboard reservation request.

Function
REQ-014 SHALL store NREGS x LANES elements of ELEN bits in flops.
REQ-015 SHALL implement a two-state FSM: CLEAR (entered on rst) and READY.
REQ-016 In CLEAR, SHALL zero one register per cycle at index clr_cnt, incrementing clr_cnt from 0 to NREGS-1, then enter READY on the following edge; ready SHALL be 1 exactly NREGS cycles after rst deasserts.
REQ-017 While not ready, SHALL ignore wr_en and rsv_valid and drive rs1_data, rs2_data, mask_data, rs1_busy, rs2_busy to 0.
REQ-018 Reads SHALL be combinational (zero latency) from the addressed register.
REQ-019 mask_data SHALL always read register MASK_REG; the lane-i mask bit is bit 0 of lane-i element of mask_data.
REQ-020 A write SHALL update lane i of register wr_addr at the clock edge iff wr_en[i]=1 and (wr_masked=0 or lane-i mask bit=1).
REQ-021 The mask bit used in REQ-020 SHALL be the pre-edge value of MASK_REG, even when wr_addr equals MASK_REG.
REQ-022 If BYPASS=1, a read port whose address equals wr_addr SHALL return, per lane, wr_data for lanes written per REQ-020 and stored data otherwise, in the same cycle; this SHALL apply to mask_data when wr_addr equals MASK_REG.
REQ-023 If BYPASS=0, reads SHALL return stored (pre-edge) data only.
REQ-024 Scoreboard: rsv_valid=1 SHALL set busy[rsv_addr] at the edge.
REQ-025 A write cycle with wr_last=1 and any wr_en bit set SHALL clear busy[wr_addr] at the edge.
REQ-026 If reserve and clear target the same register in one cycle, busy SHALL end set.
REQ-027 Reserving an already busy register SHALL leave it busy with no other effect.
REQ-028 rs1_busy/rs2_busy SHALL reflect the registered busy bits (no bypass of same-cycle set/clear).

Reset
REQ-029 rst=1 SHALL, at the next edge, set state to CLEAR, clr_cnt to 0, all busy bits to 0, ready to 0; all outputs SHALL be 0 while rst=1 or state=CLEAR.
REQ-030 rst asserted mid-CLEAR or mid-READY SHALL restart clearing from register 0; writes in progress are discarded.
REQ-031 Storage SHALL NOT be reset in one cycle; zeroing is done solely by the CLEAR sequence.

Verification
REQ-032 Reset, NREGS=32: rst high 2 cycles then low -> ready rises exactly 32 cycles later; all reads 0.
REQ-033 Write v3 all lanes 0xA5A5A5A5, wr_en=0xFF -> next cycle rs1_addr=3 reads 0xA5A5A5A5 in every lane; with BYPASS=1 same-cycle read already returns it.
REQ-034 v0 lane bits = 0b01010101, masked write to v5 of 0x11111111, wr_en=0xFF -> v5 lanes 0,2,4,6 = 0x11111111, lanes 1,3,5,7 unchanged.
REQ-035 rsv v7; later write v7 wr_last=0 -> busy stays 1; write v7 wr_last=1 -> busy 0 next cycle; same-cycle rsv v7 + last write v7 -> busy stays 1.
REQ-036 rst asserted at clr_cnt=10 after prior writes -> ready low, full 32-cycle clear reruns, all registers and busy bits read 0 afterwards.

Source files
------------

// File: rtl/vrf_multibank_if.sv
// Vector register file access bus: two read ports, a fixed mask read, one
// lane-enabled write port, and scoreboard reserve/busy signals.
interface vrf_if #(
    parameter int LANES = 8,
    parameter int NREGS = 32,
    parameter int ELEN  = 32
);
    localparam int AW = $clog2(NREGS);

    logic                        ready;
    logic [AW-1:0]               rs1_addr, rs2_addr;
    logic [LANES-1:0][ELEN-1:0]  rs1_data, rs2_data, mask_data;
    logic                        rs1_busy, rs2_busy;
    logic [AW-1:0]               wr_addr;
    logic [LANES-1:0]            wr_en;
    logic [LANES-1:0][ELEN-1:0]  wr_data;
    logic                        wr_masked, wr_last;
    logic                        rsv_valid;
    logic [AW-1:0]               rsv_addr;

    modport master (
        input  ready, rs1_data, rs2_data, mask_data, rs1_busy, rs2_busy,
        output rs1_addr, rs2_addr, wr_addr, wr_en, wr_data, wr_masked, wr_last,
               rsv_valid, rsv_addr
    );
    modport slave (
        output ready, rs1_data, rs2_data, mask_data, rs1_busy, rs2_busy,
        input  rs1_addr, rs2_addr, wr_addr, wr_en, wr_data, wr_masked, wr_last,
               rsv_valid, rsv_addr
    );
endinterface

// File: rtl/vrf_multibank.sv
// Flop-based vector register file with per-lane masked writes, optional
// write-to-read forwarding, a busy scoreboard and a sequential clear after reset.
module vrf_multibank #(
    parameter int LANES    = 8,
    parameter int NREGS    = 32,
    parameter int ELEN     = 32,
    parameter int MASK_REG = 0,
    parameter int BYPASS   = 1
) (
    input logic clk,
    input logic rst,
    vrf_if.slave bus
);
    localparam int AW = $clog2(NREGS);
    localparam logic [AW-1:0] MASK_A = AW'(MASK_REG);
    localparam logic [AW-1:0] LAST_A = AW'(NREGS - 1);

    typedef enum logic {CLEAR, READY} state_t;

    state_t                                  state, state_nxt;
    logic [AW-1:0]                           clr_cnt, clr_cnt_nxt;
    logic [NREGS-1:0][LANES-1:0][ELEN-1:0]   mem;
    logic [NREGS-1:0]                        busy;
    logic                                    act;
    logic [LANES-1:0]                        lane_we;
    logic [LANES-1:0][ELEN-1:0]              rd1, rd2, rdm;

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= CLEAR;
            clr_cnt <= '0;
        end else begin
            state   <= state_nxt;
            clr_cnt <= clr_cnt_nxt;
        end
    end

    always_comb begin
        state_nxt   = state;
        clr_cnt_nxt = clr_cnt;
        if (state == CLEAR) begin
            clr_cnt_nxt = clr_cnt + 1'b1;
            if (clr_cnt == LAST_A) state_nxt = READY;
        end
    end

    // Outputs are forced low combinationally while rst is held, not just after the edge.
    assign act = (state == READY) && !rst;

    // Storage has no reset term; only the clear sequence zeroes it.
    always_ff @(posedge clk) begin
        if (!rst && state == CLEAR) begin
            mem[clr_cnt] <= '0;
        end else if (act) begin
            for (int i = 0; i < LANES; i++)
                if (lane_we[i]) mem[bus.wr_addr][i] <= bus.wr_data[i];
        end
    end

    // Reserve is applied after clear so a same-cycle reserve wins.
    always_ff @(posedge clk) begin
        if (rst) begin
            busy <= '0;
        end else if (act) begin
            if (bus.wr_last && |bus.wr_en) busy[bus.wr_addr] <= 1'b0;
            if (bus.rsv_valid)              busy[bus.rsv_addr] <= 1'b1;
        end
    end

    for (genvar i = 0; i < LANES; i++) begin : g_lane
        logic byp1, byp2, bypm;
        // Mask bit comes from the stored MASK_REG, so a write to it never masks itself.
        assign lane_we[i] = bus.wr_en[i] & (~bus.wr_masked | mem[MASK_A][i][0]);
        assign byp1 = (BYPASS != 0) && lane_we[i] && (bus.rs1_addr == bus.wr_addr);
        assign byp2 = (BYPASS != 0) && lane_we[i] && (bus.rs2_addr == bus.wr_addr);
        assign bypm = (BYPASS != 0) && lane_we[i] && (MASK_A == bus.wr_addr);
        assign rd1[i] = byp1 ? bus.wr_data[i] : mem[bus.rs1_addr][i];
        assign rd2[i] = byp2 ? bus.wr_data[i] : mem[bus.rs2_addr][i];
        assign rdm[i] = bypm ? bus.wr_data[i] : mem[MASK_A][i];
    end

    assign bus.ready     = act;
    assign bus.rs1_data  = act ? rd1 : '0;
    assign bus.rs2_data  = act ? rd2 : '0;
    assign bus.mask_data = act ? rdm : '0;
    assign bus.rs1_busy  = act & busy[bus.rs1_addr];
    assign bus.rs2_busy  = act & busy[bus.rs2_addr];
endmodule
